alu_gumnut_mc: RTL and testbench

Parametrised, multi-cycle successor to the Gumnut combinational ALU. It keeps the Gumnut 4-bit operation encoding for arithmetic, logical and shift operations and adds an iterative unsigned multiply (low or high half). The shifter is iterative, one position per cycle, and all results and flags are registered. A valid/ready handshake lets the core datapath stall on long operations. It sits between the register-file read stage and the writeback/flag register of the core.

---
 rtl/alu_gumnut_pkg.sv | 58 +++++
 rtl/alu_gumnut_mc_if.sv | 29 ++
 rtl/alu_gumnut_arith_logic.sv | 56 +++++
 rtl/alu_gumnut_mc.sv | 199 +++++++++++++++++++
 tb/tb_alu_gumnut_mc.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_gumnut_pkg.sv
// Shared types for the multi-cycle Gumnut ALU: operation classes, sub-op
// encodings, FSM states and the s_i field decoder.
package alu_gumnut_pkg;

  typedef enum logic [2:0] {
    OPC_ARITH,
    OPC_LOGIC,
    OPC_SHIFT,
    OPC_MUL,
    OPC_RSVD
  } op_class_e;

  typedef enum logic [1:0] {
    AR_ADD  = 2'b00,
    AR_ADDC = 2'b01,
    AR_SUB  = 2'b10,
    AR_SUBC = 2'b11
  } arith_op_e;

  typedef enum logic [1:0] {
    LG_AND  = 2'b00,
    LG_OR   = 2'b01,
    LG_XOR  = 2'b10,
    LG_ANDN = 2'b11
  } logic_op_e;

  typedef enum logic [1:0] {
    SH_SHL = 2'b00,
    SH_SHR = 2'b01,
    SH_ROL = 2'b10,
    SH_ROR = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_MUL
  } state_e;

  typedef struct packed {
    op_class_e  cls;
    logic [1:0] sub;
  } op_dec_t;

  // s = {w,x,y,z}; {w,x} picks the class, {y,z} the sub-op.
  function automatic op_dec_t decode_op(input logic [3:0] s);
    op_dec_t d;
    d.sub = s[1:0];
    case (s[3:2])
      2'b00:   d.cls = OPC_ARITH;
      2'b01:   d.cls = OPC_LOGIC;
      2'b10:   d.cls = OPC_SHIFT;
      default: d.cls = s[1] ? OPC_RSVD : OPC_MUL;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_gumnut_mc_if.sv
// Request/result bundle between the register-read stage and the ALU.
interface alu_gumnut_mc_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) ();
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] rs_i;
  logic [WIDTH-1:0] op2_i;
  logic [CNT_W-1:0] count_i;
  logic             carry_i;
  logic [3:0]       s_i;
  logic             valid_o;
  logic [WIDTH-1:0] res_o;
  logic             zero_o;
  logic             carry_o;
  logic             OVF;
  logic             NF;

  modport master (
    output valid_i, rs_i, op2_i, count_i, carry_i, s_i,
    input  ready_o, valid_o, res_o, zero_o, carry_o, OVF, NF
  );

  modport slave (
    input  valid_i, rs_i, op2_i, count_i, carry_i, s_i,
    output ready_o, valid_o, res_o, zero_o, carry_o, OVF, NF
  );
endinterface

// File: rtl/alu_gumnut_arith_logic.sv
// Single-cycle add/sub/logic path with carry (or borrow) and signed overflow.
module alu_gumnut_arith_logic
  import alu_gumnut_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_i,
  input  logic             logic_sel_i,
  input  logic [1:0]       sub_i,
  output logic [WIDTH-1:0] res_o,
  output logic             carry_o,
  output logic             ovf_o
);

  logic             is_sub;
  logic             cin;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;

  // Subtraction is A + ~B + ~borrow_in; the borrow out is the inverted carry.
  always_comb begin
    is_sub = sub_i[1];
    b_eff  = is_sub ? ~b_i : b_i;
    cin    = 1'b0;
    case (arith_op_e'(sub_i))
      AR_ADD:  cin = 1'b0;
      AR_ADDC: cin = carry_i;
      AR_SUB:  cin = 1'b1;
      AR_SUBC: cin = ~carry_i;
      default: cin = 1'b0;
    endcase
    sum = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
  end

  always_comb begin
    res_o   = '0;
    carry_o = 1'b0;
    ovf_o   = 1'b0;
    if (logic_sel_i) begin
      case (logic_op_e'(sub_i))
        LG_AND:  res_o = a_i & b_i;
        LG_OR:   res_o = a_i | b_i;
        LG_XOR:  res_o = a_i ^ b_i;
        LG_ANDN: res_o = a_i & ~b_i;
        default: res_o = '0;
      endcase
    end else begin
      res_o   = sum[WIDTH-1:0];
      carry_o = is_sub ? ~sum[WIDTH] : sum[WIDTH];
      ovf_o   = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
    end
  end

endmodule

// File: rtl/alu_gumnut_mc.sv
// Multi-cycle Gumnut ALU: 1-cycle arith/logic, iterative shifter (one bit per
// cycle) and shift-add multiplier sharing one working register and counter.
module alu_gumnut_mc
  import alu_gumnut_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  alu_gumnut_mc_if.slave bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [CNT_W:0]   cnt_q, cnt_d;
  logic [1:0]       sub_q, sub_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             valid_q, valid_d;

  op_dec_t          dec;
  logic [CNT_W:0]   cnt_eff;
  logic [WIDTH-1:0] al_res;
  logic             al_carry;
  logic             al_ovf;
  logic [WIDTH-1:0] sh_w;
  logic             sh_c;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] mul_lo;

  alu_gumnut_arith_logic #(
    .WIDTH (WIDTH)
  ) u_arith_logic (
    .a_i         (bus.rs_i),
    .b_i         (bus.op2_i),
    .carry_i     (bus.carry_i),
    .logic_sel_i (dec.cls == OPC_LOGIC),
    .sub_i       (dec.sub),
    .res_o       (al_res),
    .carry_o     (al_carry),
    .ovf_o       (al_ovf)
  );

  always_comb begin
    dec     = decode_op(bus.s_i);
    cnt_eff = (CNT_W+1)'(32'(bus.count_i) % WIDTH);
  end

  // One shift/rotate step on the working register.
  always_comb begin
    sh_w = work_q;
    sh_c = 1'b0;
    case (shift_op_e'(sub_q))
      SH_SHL: begin sh_w = {work_q[WIDTH-2:0], 1'b0};            sh_c = work_q[WIDTH-1]; end
      SH_SHR: begin sh_w = {1'b0, work_q[WIDTH-1:1]};            sh_c = work_q[0];       end
      SH_ROL: begin sh_w = {work_q[WIDTH-2:0], work_q[WIDTH-1]}; sh_c = work_q[WIDTH-1]; end
      SH_ROR: begin sh_w = {work_q[0], work_q[WIDTH-1:1]};       sh_c = work_q[0];       end
      default: begin sh_w = work_q; sh_c = 1'b0; end
    endcase
  end

  // Shift-add step: {acc, work} holds partial product high half and the
  // remaining multiplier bits; both shift right together each cycle.
  always_comb begin
    mul_sum = {1'b0, acc_q} + (work_q[0] ? {1'b0, mcand_q} : '0);
    mul_hi  = mul_sum[WIDTH:1];
    mul_lo  = {mul_sum[0], work_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    sub_d   = sub_q;
    res_d   = res_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.valid_i) begin
          sub_d = dec.sub;
          case (dec.cls)
            OPC_ARITH, OPC_LOGIC: begin
              valid_d = 1'b1;
              res_d   = al_res;
              carry_d = al_carry;
              ovf_d   = al_ovf;
              zero_d  = (al_res == '0);
            end
            OPC_SHIFT: begin
              if (cnt_eff == '0) begin
                valid_d = 1'b1;
                res_d   = bus.rs_i;
                carry_d = 1'b0;
                ovf_d   = 1'b0;
                zero_d  = (bus.rs_i == '0);
              end else begin
                work_d  = bus.rs_i;
                cnt_d   = cnt_eff;
                state_d = ST_SHIFT;
              end
            end
            OPC_MUL: begin
              work_d  = bus.rs_i;
              mcand_d = bus.op2_i;
              acc_d   = '0;
              cnt_d   = (CNT_W+1)'(WIDTH);
              state_d = ST_MUL;
            end
            default: begin
              valid_d = 1'b1;
              res_d   = '0;
              carry_d = 1'b0;
              ovf_d   = 1'b0;
              zero_d  = 1'b1;
            end
          endcase
        end
      end

      ST_SHIFT: begin
        work_d = sh_w;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == (CNT_W+1)'(1)) begin
          valid_d = 1'b1;
          res_d   = sh_w;
          carry_d = sh_c;
          ovf_d   = 1'b0;
          zero_d  = (sh_w == '0);
          state_d = ST_IDLE;
        end
      end

      ST_MUL: begin
        acc_d  = mul_hi;
        work_d = mul_lo;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == (CNT_W+1)'(1)) begin
          valid_d = 1'b1;
          res_d   = sub_q[0] ? mul_hi : mul_lo;
          carry_d = 1'b0;
          ovf_d   = (mul_hi != '0);
          zero_d  = ((sub_q[0] ? mul_hi : mul_lo) == '0);
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      sub_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      sub_q   <= sub_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
    end
  end

  assign bus.ready_o = (state_q == ST_IDLE);
  assign bus.valid_o = valid_q;
  assign bus.res_o   = res_q;
  assign bus.zero_o  = zero_q;
  assign bus.carry_o = carry_q;
  assign bus.OVF     = ovf_q;
  assign bus.NF      = res_q[WIDTH-1];

endmodule

// File: tb/tb_alu_gumnut_mc.sv
// Directed + randomised scoreboard bench for alu_gumnut_mc (WIDTH=8).
module tb_alu_gumnut_mc;
  localparam int unsigned W  = 8;
  localparam int unsigned CW = $clog2(W);

  typedef struct {
    logic [W-1:0] res;
    logic         carry;
    logic         ovf;
    logic         zero;
    logic         nf;
    int unsigned  cyc;
    string        tag;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned cyc   = 0;
  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        sb[$];

  alu_gumnut_mc_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  alu_gumnut_mc #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input int unsigned c, input logic cin);
    exp_t        e;
    int          t, st, ci;
    int unsigned ua, r;
    logic [15:0] p;
    e.res = '0; e.carry = 1'b0; e.ovf = 1'b0; e.cyc = 0; e.tag = "";
    ua = int'(a);
    case (s[3:2])
      2'b00: begin
        ci = s[0] ? int'(cin) : 0;
        if (!s[1]) begin
          t = int'(a) + int'(b) + ci;  st = int'($signed(a)) + int'($signed(b)) + ci;
          e.carry = (t > 255);
        end else begin
          t = int'(a) - int'(b) - ci;  st = int'($signed(a)) - int'($signed(b)) - ci;
          e.carry = (t < 0);
        end
        e.res = t[7:0];
        e.ovf = (st > 127) || (st < -128);
      end
      2'b01: case (s[1:0])
        2'b00: e.res = a & b;
        2'b01: e.res = a | b;
        2'b10: e.res = a ^ b;
        default: e.res = a & ~b;
      endcase
      2'b10: case (s[1:0])
        2'b00: begin r = ua << c; e.res = r[7:0]; e.carry = (c != 0) && r[8]; end
        2'b01: begin r = ua >> c; e.res = r[7:0]; e.carry = (c != 0) && ((ua >> (c - 1)) & 1) != 0; end
        2'b10: begin r = (ua << c) | (ua >> (8 - c)); e.res = r[7:0]; e.carry = (c != 0) && r[0]; end
        default: begin r = (ua >> c) | (ua << (8 - c)); e.res = r[7:0]; e.carry = (c != 0) && r[7]; end
      endcase
      default: if (!s[1]) begin
        p = a * b;
        e.res = s[0] ? p[15:8] : p[7:0];
        e.ovf = (p[15:8] != 8'h00);
      end
    endcase
    e.zero = (e.res == '0);
    e.nf   = e.res[7];
    return e;
  endfunction

  // Drive one request for a cycle; expected result is queued only if accepted.
  task automatic issue(input string tag, input logic [3:0] s, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int unsigned c, input logic cin);
    exp_t        e;
    int unsigned lat;
    bus.valid_i = 1'b1; bus.s_i = s; bus.rs_i = a; bus.op2_i = b;
    bus.count_i = CW'(c); bus.carry_i = cin;
    if (s[3:2] == 2'b10)      lat = (c != 0) ? c + 1 : 1;
    else if (s[3:1] == 3'b110) lat = W + 1;
    else                       lat = 1;
    if (bus.ready_o === 1'b1) begin
      e = model(s, a, b, c, cin);
      e.cyc = cyc + lat;
      e.tag = tag;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
  endtask

  task automatic drain(input int unsigned max);
    int unsigned n = 0;
    do begin @(posedge clk); #1; n++; end while (sb.size() != 0 && n < max);
    chk("drain_timeout", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.valid_o === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_valid_o", 1, 0);
      else begin
        e = sb.pop_front();
        chk({e.tag, ".res"},   bus.res_o,   e.res);
        chk({e.tag, ".carry"}, bus.carry_o, e.carry);
        chk({e.tag, ".ovf"},   bus.OVF,     e.ovf);
        chk({e.tag, ".zero"},  bus.zero_o,  e.zero);
        chk({e.tag, ".nf"},    bus.NF,      e.nf);
        chk({e.tag, ".lat"},   cyc,         e.cyc);
      end
    end
  end

  initial begin
    bus.valid_i = 1'b0; bus.s_i = 4'h0; bus.rs_i = '0; bus.op2_i = '0;
    bus.count_i = '0; bus.carry_i = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst.res",   bus.res_o,   0);
    chk("rst.valid", bus.valid_o, 0);
    chk("rst.carry", bus.carry_o, 0);
    chk("rst.ovf",   bus.OVF,     0);
    chk("rst.nf",    bus.NF,      0);
    chk("rst.zero",  bus.zero_o,  0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst.ready", bus.ready_o, 1);

    issue("add_7f_01", 4'b0000, 8'h7F, 8'h01, 0, 1'b0);
    drain(20);
    issue("sub_10_20", 4'b0010, 8'h10, 8'h20, 0, 1'b0);
    issue("subc_00_00", 4'b0011, 8'h00, 8'h00, 0, 1'b1);
    issue("addc_ff_00", 4'b0001, 8'hFF, 8'h00, 0, 1'b1);
    drain(20);

    issue("shl_e1_3", 4'b1000, 8'hE1, 8'h00, 3, 1'b0);
    chk("shift.busy1", bus.ready_o, 0);
    issue("ignored_add", 4'b0000, 8'h11, 8'h22, 0, 1'b0);
    chk("shift.busy2", bus.ready_o, 0);
    @(posedge clk); #1;
    chk("shift.busy3", bus.ready_o, 0);
    @(posedge clk); #1;
    chk("shift.ready", bus.ready_o, 1);
    drain(20);
    issue("ror_01_0", 4'b1011, 8'h01, 8'h00, 0, 1'b0);
    issue("shr_81_1", 4'b1001, 8'h81, 8'h00, 1, 1'b0);
    drain(20);
    issue("rol_96_7", 4'b1010, 8'h96, 8'h00, 7, 1'b0);
    drain(20);

    issue("mullo_10_10", 4'b1100, 8'h10, 8'h10, 0, 1'b0);
    drain(30);
    issue("mulhi_10_10", 4'b1101, 8'h10, 8'h10, 0, 1'b0);
    drain(30);
    repeat (3) @(posedge clk);
    #1;
    chk("hold.res", bus.res_o, 8'h01);
    chk("hold.ovf", bus.OVF,   1);

    issue("mul_reset", 4'b1100, 8'h0F, 8'h0F, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst.res",   bus.res_o,   0);
    chk("midrst.valid", bus.valid_o, 0);
    chk("midrst.carry", bus.carry_o, 0);
    chk("midrst.ovf",   bus.OVF,     0);
    chk("midrst.nf",    bus.NF,      0);
    chk("midrst.zero",  bus.zero_o,  0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst.ready", bus.ready_o, 1);
    repeat (12) @(posedge clk);
    #1;

    issue("rsvd_e", 4'b1110, 8'hAA, 8'h55, 0, 1'b0);
    issue("rsvd_f", 4'b1111, 8'h80, 8'h80, 0, 1'b1);
    for (int i = 0; i < 4; i++)
      issue($sformatf("logic_%0d", i), 4'(4 + i), 8'($urandom), 8'($urandom), 0, 1'b0);
    for (int i = 0; i < 16; i++)
      issue($sformatf("b2b_arith_%0d", i), 4'($urandom_range(0, 3)), 8'($urandom),
            8'($urandom), 0, 1'($urandom));
    drain(20);

    for (int i = 0; i < 8; i++) begin
      issue($sformatf("rnd_shift_%0d", i), 4'(8 + $urandom_range(0, 3)), 8'($urandom),
            8'h00, $urandom_range(0, 7), 1'b0);
      drain(20);
    end
    for (int i = 0; i < 4; i++) begin
      issue($sformatf("rnd_mul_%0d", i), 4'(12 + (i % 2)), 8'($urandom), 8'($urandom), 0, 1'b0);
      drain(30);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
